// File: rtl/cpu_alu_pkg.sv
// Shared CPU ALU definitions: word/rotate widths, opcodes and rotate FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   WORD_W      - ALU data width
//   ROT_AMT_W   - rotate-amount width (amount is taken modulo WORD_W)
//   alu_op_t    - ALU opcode encoding, including both rotate directions
//   rot_state_t - state encoding for the sequential rotate units
package cpu_alu_pkg;

  localparam int WORD_W    = 16;
  localparam int ROT_AMT_W = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ROR = 4'd8,
    OP_ROL = 4'd9
  } alu_op_t;

  typedef enum logic {
    ROT_IDLE  = 1'b0,
    ROT_SHIFT = 1'b1
  } rot_state_t;

endpackage

// File: rtl/rol_seq_unit_if.sv
// Start/done handshake bundle between the ALU control FSM and the rotate-left unit.
// Latency: n/a (wires only).
// Backpressure: master may only expect a start to be taken while ready=1.
//
// Signals:
//   start  - request pulse from the controller
//   A, B   - operand and rotate amount (amount in the low bits of B)
//   ready  - unit idle, start will be accepted on the next edge
//   busy   - rotation in progress (always ~ready)
//   done   - one-cycle pulse, ROL/cout valid
//   ROL    - rotated result, held until the next accept
//   cout   - last bit rotated out of the MSB
interface rol_seq_unit_if #(
  parameter int WIDTH = cpu_alu_pkg::WORD_W
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ROL;
  logic             cout;

  // Controller side.
  modport master (
    output start, A, B,
    input  ready, busy, done, ROL, cout
  );

  // Rotate unit side.
  modport slave (
    input  start, A, B,
    output ready, busy, done, ROL, cout
  );

endinterface

// File: rtl/rol_barrel.sv
// Combinational WIDTH-bit rotate-left by a variable amount (log2 mux stages).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   din  - value to rotate
//   amt  - rotate amount; stage s rotates by 2**s when amt[s] is set
//   dout - din rotated left by amt (modulo WIDTH)
// A right-rotate by N is obtained by feeding amt = WIDTH-N.
module rol_barrel #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [AMT_W+1];

  assign stage[0] = din;

  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    // Rotating by a multiple of WIDTH is the identity, so such a stage is a wire.
    localparam int SH = (1 << s) % WIDTH;
    if (SH == 0) begin : g_pass
      assign stage[s+1] = stage[s];
    end else begin : g_rot
      assign stage[s+1] = amt[s] ? ((stage[s] << SH) | (stage[s] >> (WIDTH - SH)))
                                 : stage[s];
    end
  end

  assign dout = stage[AMT_W];

endmodule

// File: rtl/rol_seq_unit.sv
// Rotate-left execution unit: rotates A left by B[AMT_W-1:0] under a start/done handshake.
// Latency: done N cycles after accept (N = amount), 0 extra cycles when N=0 or barrel build.
// Backpressure: ready=0 while rotating; start is ignored (not queued) when not ready.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset; wins over a simultaneous start
//   io    - rol_seq_unit_if.slave: start/A/B in, ready/busy/done/ROL/cout out
//
// Build option: define ROL_SEQ_BARREL_EN to replace the one-bit-per-cycle
// SHIFT loop with a single-cycle barrel rotator (done on every accept edge,
// busy never asserted). Port list is identical in both builds.
module rol_seq_unit
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int AMT_W = ROT_AMT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  rol_seq_unit_if.slave  io
);

  rot_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic             cout_q,  cout_d;
  logic             done_q,  done_d;

  logic [AMT_W-1:0] amt;

  // Only the low bits of B carry the amount, which makes the rotate modulo WIDTH.
  assign amt = io.B[AMT_W-1:0];

  logic unused_b_hi;
  assign unused_b_hi = ^io.B[WIDTH-1:AMT_W];

`ifdef ROL_SEQ_BARREL_EN
  logic [WIDTH-1:0] rot_full;

  rol_barrel #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_barrel (
    .din  (io.A),
    .amt  (amt),
    .dout (rot_full)
  );
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      ROT_IDLE: begin
        if (io.start) begin
`ifdef ROL_SEQ_BARREL_EN
          // Whole rotate in one step; the bit that ended up in position 0
          // is the last one that left the MSB.
          data_d = rot_full;
          cnt_d  = '0;
          cout_d = (amt != '0) && rot_full[0];
          done_d = 1'b1;
`else
          data_d = io.A;
          cnt_d  = amt;
          cout_d = 1'b0;
          if (amt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ROT_SHIFT;
          end
`endif
        end
      end

      ROT_SHIFT: begin
        data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        cout_d = data_q[WIDTH-1];
        cnt_d  = cnt_q - AMT_W'(1);
        // cnt==1 means this edge performs the final single-bit rotate.
        if (cnt_q == AMT_W'(1)) begin
          done_d  = 1'b1;
          state_d = ROT_IDLE;
        end
      end

      default: begin
        state_d = ROT_IDLE;
      end
    endcase
  end

  // State register; reset discards any in-flight rotate without a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ROT_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign io.ROL   = data_q;
  assign io.cout  = cout_q;
  assign io.done  = done_q;
  assign io.busy  = (state_q == ROT_SHIFT);
  assign io.ready = (state_q == ROT_IDLE);

endmodule

// File: doc/rol_seq_unit.md
Name: rol_seq_unit

Overview:
- Multi-cycle rotate-left execution unit for the 16-bit CPU ALU. It is the left-direction counterpart of the existing rotate-right path.
- It rotates operand A left by B[3:0] positions, one bit per clock, under a start/done handshake.
- It sits beside the combinational ALU ops. The control FSM stalls on busy and captures ROL on done.

Parameters:
- WIDTH, 16, data width of operand and result.
- AMT_W, 4, rotate-amount width. Amount is B[AMT_W-1:0], so the rotate is modulo WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; accepted only when ready=1.
- A  input  WIDTH  operand to rotate; sampled on the accept edge.
- B  input  WIDTH  rotate amount in low AMT_W bits; upper bits ignored; sampled on the accept edge.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while rotation is in progress; equals ~ready.
- done  output  1  one-cycle pulse; ROL and cout are valid in that cycle.
- ROL  output  WIDTH  rotated result; holds its value until the next accept.
- cout  output  1  last bit rotated out of the MSB (the new bit 0); 0 if the amount is 0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: state=IDLE, ROL=0, cout=0, done=0, busy=0, ready=1, internal counter=0.
- States: IDLE and SHIFT.
- Accept: at a rising edge with start=1 and state=IDLE (edge E0), latch A into the data register and N=B[AMT_W-1:0] into the counter.
  - If N=0: done<=1 at E0, ROL=A, cout=0, stay IDLE.
  - If N>0: go to SHIFT, busy<=1, cout<=0.
- SHIFT, each edge:
  - data <= {data[WIDTH-2:0], data[WIDTH-1]}.
  - cout <= old data[WIDTH-1].
  - cnt <= cnt-1.
  - On the edge where cnt==1, done<=1, busy<=0, and the next state is IDLE.
- Latency:
  - N>=1: done is registered at edge E0+N, so done is high during the cycle after that edge.
  - N=0: done is registered at E0.
- ROL is driven directly from the data register. Intermediate values are visible but are only defined as valid in the done cycle.
- done lasts exactly one cycle. A new start in the done cycle is accepted, because ready=1 there.
- start while busy: ignored, with no queuing. A and B are don't-care while busy.
- Rotation preserves all bits. The popcount of ROL equals the popcount of A.
- Boundary cases:
  - N=WIDTH-1 is the longest operation (15 cycles).
  - Rotating by 15 is equivalent to rotate-right by 1.
- Reset mid-operation: rst_n=0 at any edge forces all reset values. The in-flight operation is discarded and no done is issued.
- Simultaneous rst_n=0 and start=1: reset wins.

Optional Feature:
- Macro: ROL_SEQ_BARREL_EN.
- Defined: a combinational barrel rotator (log2 WIDTH mux stages) replaces SHIFT.
  - Every accepted start produces done at E0, with the full rotate result and cout = result[0] when N>0 (0 when N=0).
  - busy is never asserted.
- Undefined: the iterative one-bit-per-cycle behaviour above, which is smaller in area.
- Port list is identical in both builds.

Decomposition:
- Shared package cpu_alu_pkg holds:
  - WORD_W=16 and ROT_AMT_W=4;
  - alu_op_t opcode enum, including OP_ROR and OP_ROL;
  - rot_state_t enum {ROT_IDLE, ROT_SHIFT}.
- One natural sub-module: rol_barrel, a combinational WIDTH-bit rotate-by-amount. It is used only under ROL_SEQ_BARREL_EN and is reusable later for a right-rotate by amount (WIDTH-N).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> ROL=0x0000, done=0, busy=0, ready=1.
- Basic: A=0x8001, B=0x0001, start -> done after 1 cycle, ROL=0x0003, cout=1.
- Multi-cycle: A=0x1234, B=0x0004 -> busy for 4 cycles, done at E0+4, ROL=0x2341, cout=1. start pulses during busy are ignored.
- Zero and modulo amount:
  - A=0xBEEF, B=0x0000 -> done at E0, ROL=0xBEEF, cout=0.
  - B=0xFFF0 (amount 0) gives the same result.
  - A=0x0001, B=0x000F -> ROL=0x8000.
- Reset mid-op: A=0x00FF, B=0x000A, assert rst_n=0 at E0+3 -> no done ever. ROL=0 and ready=1 the cycle after.
- Back-to-back: new start in the done cycle (A=0x0F00, B=0x0008) -> accepted, second done gives ROL=0x000F. Repeat with ROL_SEQ_BARREL_EN defined: both dones at their accept edges, busy never high.
